// File: rtl/axil_regfile_pkg.sv
// rtl/axil_regfile_pkg.sv - shared response codes and address helpers for the AXI4-Lite register file
package axil_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Byte-address bits below the word index for a given bus width.
  function automatic int addr_lsb(input int data_width);
    return clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_skid_buffer.sv
// rtl/axil_skid_buffer.sv - one-entry skid buffer with registered upstream ready
module axil_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata
);

  logic             full_q, full_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (m_tready) full_d = 1'b0;
    end else if (s_tvalid && !m_tready) begin
      full_d = 1'b1;
      data_d = s_tdata;
    end
    ready_d = !full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

  // A held entry always takes priority over the live input.
  assign s_tready = ready_q;
  assign m_tvalid = full_q || s_tvalid;
  assign m_tdata  = full_q ? data_q : s_tdata;

endmodule

// File: rtl/s_axi_lite_regfile.sv
// rtl/s_axi_lite_regfile.sv - AXI4-Lite slave register file with RW storage and RO status slots
// Define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses and RO writes with SLVERR.
module s_axi_lite_regfile
  import axil_regfile_pkg::*;
#(
  parameter int                C_S_AXI_DATA_WIDTH = 32,
  parameter int                C_S_AXI_ADDR_WIDTH = 8,
  parameter int                N_REGS             = 16,
  parameter logic [N_REGS-1:0] RO_MASK            = '0
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [N_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [N_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [N_REGS-1:0]                    reg_wr
);

  localparam int          DW       = C_S_AXI_DATA_WIDTH;
  localparam int          AW       = C_S_AXI_ADDR_WIDTH;
  localparam int          NB       = DW / 8;
  localparam int          ADDR_LSB = addr_lsb(DW);
  localparam logic [31:0] N_REGS_U = N_REGS;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  logic          aw_tvalid, w_tvalid, ar_tvalid;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [DW-1:0] w_data;
  logic [NB-1:0] w_strb;
  logic          wr_fire, rd_fire;
  logic [31:0]   aw_idx, ar_idx;
  logic          wr_oor, wr_ro, rd_oor;
  logic [DW-1:0] rd_data;

  logic [N_REGS*DW-1:0] storage_q, storage_d;
  logic [N_REGS-1:0]    reg_wr_q, reg_wr_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 rvalid_q, rvalid_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [DW-1:0]        rdata_q, rdata_d;

  axil_skid_buffer #(.WIDTH(AW)) u_aw_skid (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETn),
    .s_tvalid (S_AXI_AWVALID),
    .s_tready (S_AXI_AWREADY),
    .s_tdata  (S_AXI_AWADDR),
    .m_tvalid (aw_tvalid),
    .m_tready (wr_fire),
    .m_tdata  (aw_addr)
  );

  axil_skid_buffer #(.WIDTH(NB + DW)) u_w_skid (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETn),
    .s_tvalid (S_AXI_WVALID),
    .s_tready (S_AXI_WREADY),
    .s_tdata  ({S_AXI_WSTRB, S_AXI_WDATA}),
    .m_tvalid (w_tvalid),
    .m_tready (wr_fire),
    .m_tdata  ({w_strb, w_data})
  );

  axil_skid_buffer #(.WIDTH(AW)) u_ar_skid (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETn),
    .s_tvalid (S_AXI_ARVALID),
    .s_tready (S_AXI_ARREADY),
    .s_tdata  (S_AXI_ARADDR),
    .m_tvalid (ar_tvalid),
    .m_tready (rd_fire),
    .m_tdata  (ar_addr)
  );

  // A response channel only blocks new work while its beat is actually stuck.
  assign wr_fire = aw_tvalid && w_tvalid && !(bvalid_q && !S_AXI_BREADY);
  assign rd_fire = ar_tvalid && !(rvalid_q && !S_AXI_RREADY);

  assign aw_idx = 32'(aw_addr >> ADDR_LSB);
  assign ar_idx = 32'(ar_addr >> ADDR_LSB);
  assign wr_oor = aw_idx >= N_REGS_U;
  assign rd_oor = ar_idx >= N_REGS_U;

  always_comb begin
    wr_ro   = 1'b0;
    rd_data = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (aw_idx == 32'(i) && RO_MASK[i]) wr_ro = 1'b1;
      if (ar_idx == 32'(i)) rd_data = RO_MASK[i] ? reg_in[i*DW +: DW] : storage_q[i*DW +: DW];
    end
  end

  always_comb begin
    storage_d = storage_q;
    reg_wr_d  = '0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    if (S_AXI_BREADY) bvalid_d = 1'b0;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = (SLVERR_EN && (wr_oor || wr_ro)) ? RESP_SLVERR : RESP_OKAY;
      for (int i = 0; i < N_REGS; i++) begin
        if (aw_idx == 32'(i) && !RO_MASK[i]) begin
          reg_wr_d[i] = 1'b1;
          for (int b = 0; b < NB; b++) begin
            if (w_strb[b]) storage_d[i*DW + b*8 +: 8] = w_data[b*8 +: 8];
          end
        end
      end
    end

    // rd_data comes from storage_q, so a same-cycle write is not yet visible.
    if (S_AXI_RREADY) rvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = (SLVERR_EN && rd_oor) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETn) begin
    if (!S_AXI_ARESETn) begin
      storage_q <= '0;
      reg_wr_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      storage_q <= storage_d;
      reg_wr_q  <= reg_wr_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  for (genvar i = 0; i < N_REGS; i++) begin : g_reg_out
    assign reg_out[i*DW +: DW] = RO_MASK[i] ? '0 : storage_q[i*DW +: DW];
  end

  assign reg_wr       = reg_wr_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

endmodule

// File: tb/tb_s_axi_lite_regfile.sv
// tb/tb_s_axi_lite_regfile.sv - directed self-checking bench for s_axi_lite_regfile
module tb_s_axi_lite_regfile;

  localparam int          DW = 32;
  localparam int          AW = 12;
  localparam int          N  = 16;
  localparam logic [N-1:0] RO = 16'h0020;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;
  logic [N*DW-1:0] reg_out, reg_in;
  logic [N-1:0]    reg_wr;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  s_axi_lite_regfile #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .N_REGS             (N),
    .RO_MASK            (RO)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETn (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .reg_in        (reg_in),
    .reg_wr        (reg_wr)
  );

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [DW/8-1:0] strb, output logic [1:0] resp,
                           output logic [N-1:0] wr_seen, output logic ok);
    logic aw_done, w_done, aw_hs, w_hs;
    int   cnt;
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; cnt = 0;
    wr_seen = '0; resp = 2'b11; ok = 1'b0;
    while (!(aw_done && w_done) && cnt < 30) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      wr_seen = wr_seen | reg_wr;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
      cnt++;
    end
    while (!ok && cnt < 60) begin
      if (bvalid) begin resp = bresp; ok = 1'b1; end
      @(posedge clk); #1;
      wr_seen = wr_seen | reg_wr;
      cnt++;
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp, output logic ok);
    logic ar_done, ar_hs;
    int   cnt;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    ar_done = 1'b0; cnt = 0; ok = 1'b0; data = 'x; resp = 2'b11;
    while (!ar_done && cnt < 30) begin
      ar_hs = arvalid && arready;
      @(posedge clk); #1;
      if (ar_hs) begin arvalid = 1'b0; ar_done = 1'b1; end
      cnt++;
    end
    while (!ok && cnt < 60) begin
      if (rvalid) begin data = rdata; resp = rresp; ok = 1'b1; end
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          ok;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      tests_failed++; $display("FAIL reset_ready: got %b want 111", {awready, wready, arready});
    end
    tests_run++;
    if ({bvalid, rvalid} !== 2'b00 || reg_wr !== 16'h0000 || bresp !== 2'b00 || rresp !== 2'b00) begin
      tests_failed++; $display("FAIL reset_resp: bvalid=%b rvalid=%b reg_wr=%h bresp=%b rresp=%b want all 0",
                               bvalid, rvalid, reg_wr, bresp, rresp);
    end
    tests_run++;
    if (reg_out !== '0 || rdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_storage: reg_out=%h rdata=%h want 0", reg_out, rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      axi_read(12'(i * 4), d, r, ok);
      tests_run++;
      if (!ok || d !== 32'h0 || r !== 2'b00) begin
        tests_failed++; $display("FAIL reset_read reg%0d: ok=%b rdata=%h rresp=%b want 1/00000000/00", i, ok, d, r);
      end
    end
  endtask

  task automatic test_strobe();
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          ok;
    awaddr = 12'h008; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b1 || reg_wr !== 16'h0004 || reg_out[2*DW +: DW] !== 32'h00AD00EF) begin
      tests_failed++; $display("FAIL strobe_fire: bvalid=%b reg_wr=%h reg2=%h want 1/0004/00ad00ef",
                               bvalid, reg_wr, reg_out[2*DW +: DW]);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bvalid !== 1'b0 || reg_wr !== 16'h0000) begin
      tests_failed++; $display("FAIL strobe_pulse: bvalid=%b reg_wr=%h want 0/0000", bvalid, reg_wr);
    end
    axi_read(12'h008, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h00AD00EF || r !== 2'b00) begin
      tests_failed++; $display("FAIL strobe_read: ok=%b rdata=%h rresp=%b want 1/00ad00ef/00", ok, d, r);
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] d;
    logic [1:0]    r, br;
    logic [N-1:0]  ws;
    logic          ok_r, ok_w;
    fork
      axi_write(12'h008, 32'h11223344, 4'hF, br, ws, ok_w);
      axi_read(12'h008, d, r, ok_r);
    join
    tests_run++;
    if (!ok_w || !ok_r || d !== 32'h00AD00EF) begin
      tests_failed++; $display("FAIL same_cycle_read: ok=%b%b rdata=%h want 11/00ad00ef", ok_w, ok_r, d);
    end
    axi_read(12'h008, d, r, ok_r);
    tests_run++;
    if (!ok_r || d !== 32'h11223344) begin
      tests_failed++; $display("FAIL same_cycle_after: rdata=%h want 11223344", d);
    end
  endtask

  task automatic test_w_before_aw();
    int early_b;
    int late_b;
    early_b = 0; late_b = 0;
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    if (bvalid) early_b++;
    tests_run++;
    if (wready !== 1'b0) begin
      tests_failed++; $display("FAIL w_first_wready: got %b want 0", wready);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (bvalid) early_b++;
    end
    awaddr = 12'h00C; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    tests_run++;
    if (early_b != 0 || bvalid !== 1'b1 || reg_wr !== 16'h0008 || reg_out[3*DW +: DW] !== 32'h12345678) begin
      tests_failed++; $display("FAIL w_first_fire: early_b=%0d bvalid=%b reg_wr=%h reg3=%h want 0/1/0008/12345678",
                               early_b, bvalid, reg_wr, reg_out[3*DW +: DW]);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bvalid) late_b++;
    end
    tests_run++;
    if (late_b != 0 || wready !== 1'b1) begin
      tests_failed++; $display("FAIL w_first_single: extra_b=%0d wready=%b want 0/1", late_b, wready);
    end
  endtask

  task automatic test_ro();
    logic [DW-1:0] d;
    logic [1:0]    r, br;
    logic [N-1:0]  ws;
    logic          ok;
    reg_in[5*DW +: DW] = 32'hCAFE0001;
    axi_write(12'h014, 32'hFFFFFFFF, 4'hF, br, ws, ok);
    tests_run++;
    if (!ok || br !== ERR_RESP || ws !== 16'h0000) begin
      tests_failed++; $display("FAIL ro_write: ok=%b bresp=%b reg_wr_seen=%h want 1/%b/0000", ok, br, ws, ERR_RESP);
    end
    axi_read(12'h014, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'hCAFE0001 || r !== 2'b00 || reg_out[5*DW +: DW] !== 32'h0) begin
      tests_failed++; $display("FAIL ro_read: ok=%b rdata=%h rresp=%b slot5=%h want 1/cafe0001/00/0",
                               ok, d, r, reg_out[5*DW +: DW]);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]  order[$];
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          ok;
    int            beats, bad_resp;
    logic          drv_timeout;
    beats = 0; bad_resp = 0; drv_timeout = 1'b0;
    bready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          logic hs;
          int   c;
          awaddr = 12'(24 + 4 * k); awvalid = 1'b1;
          wdata = 32'hA0000001 + 32'(k); wstrb = 4'hF; wvalid = 1'b1;
          hs = 1'b0; c = 0;
          while (!hs && c < 20) begin
            hs = awready && wready;
            @(posedge clk); #1;
            c++;
          end
          if (!hs) drv_timeout = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
      end
      begin
        for (int cyc = 1; cyc <= 20; cyc++) begin
          @(posedge clk); #1;
          if (reg_wr != 16'h0000) order.push_back(reg_wr);
          if (cyc == 2) begin
            tests_run++;
            if (awready !== 1'b0 || wready !== 1'b0) begin
              tests_failed++; $display("FAIL bp_ready_drop: awready=%b wready=%b want 0/0", awready, wready);
            end
          end
          if (cyc == 4) bready = 1'b1;
          if (cyc >= 4 && bvalid && bready) begin
            beats++;
            if (bresp !== 2'b00) bad_resp++;
          end
        end
      end
    join
    tests_run++;
    if (drv_timeout || beats != 3 || bad_resp != 0) begin
      tests_failed++; $display("FAIL bp_beats: timeout=%b beats=%0d bad_resp=%0d want 0/3/0", drv_timeout, beats, bad_resp);
    end
    tests_run++;
    if (order.size() != 3 || order[0] !== 16'h0040 || order[1] !== 16'h0080 || order[2] !== 16'h0100) begin
      tests_failed++; $display("FAIL bp_order: pulses=%0d first=%h want 3 pulses 0040,0080,0100",
                               order.size(), (order.size() > 0) ? order[0] : 16'hxxxx);
    end
    for (int k = 0; k < 3; k++) begin
      axi_read(12'(24 + 4 * k), d, r, ok);
      tests_run++;
      if (!ok || d !== 32'hA0000001 + 32'(k)) begin
        tests_failed++; $display("FAIL bp_data reg%0d: ok=%b rdata=%h want %h", 6 + k, ok, d, 32'hA0000001 + 32'(k));
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [DW-1:0] d;
    logic [1:0]    r, br;
    logic [N-1:0]  ws;
    logic          ok_r, ok_w;
    fork
      axi_write(12'h000, 32'h5A5A5A5A, 4'hF, br, ws, ok_w);
      axi_read(12'h100, d, r, ok_r);
    join
    tests_run++;
    if (!ok_r || d !== 32'h0 || r !== ERR_RESP) begin
      tests_failed++; $display("FAIL oor_read: ok=%b rdata=%h rresp=%b want 1/00000000/%b", ok_r, d, r, ERR_RESP);
    end
    tests_run++;
    if (!ok_w || br !== 2'b00 || ws !== 16'h0001 || reg_out[0 +: DW] !== 32'h5A5A5A5A) begin
      tests_failed++; $display("FAIL oor_concurrent_write: ok=%b bresp=%b reg_wr_seen=%h reg0=%h want 1/00/0001/5a5a5a5a",
                               ok_w, br, ws, reg_out[0 +: DW]);
    end
    axi_write(12'h100, 32'hFFFFFFFF, 4'hF, br, ws, ok_w);
    tests_run++;
    if (!ok_w || br !== ERR_RESP || ws !== 16'h0000) begin
      tests_failed++; $display("FAIL oor_write: ok=%b bresp=%b reg_wr_seen=%h want 1/%b/0000", ok_w, br, ws, ERR_RESP);
    end
    axi_read(12'h000, d, r, ok_r);
    tests_run++;
    if (!ok_r || d !== 32'h5A5A5A5A) begin
      tests_failed++; $display("FAIL oor_reg0_kept: rdata=%h want 5a5a5a5a", d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
    reg_in = '0;
    test_reset();
    test_strobe();
    test_same_cycle();
    test_w_before_aw();
    test_ro();
    test_back_to_back();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/s_axi_lite_regfile.md
# s_axi_lite_regfile

Parametrised AXI4-Lite slave register file for PL control/status. It generalises the fixed 32-bit register template to configurable data width, register count and per-register read-only status mapping. It adds fabric-visible register outputs with write strobes and defined out-of-range handling. It sits between the PS/interconnect AXI4-Lite master and user logic.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus width; 32 or 64 only.
- C_S_AXI_ADDR_WIDTH, 8, byte-address width; must cover N_REGS words.
- N_REGS, 16, number of registers; 1..256.
- RO_MASK, 0 (N_REGS bits), bit i = 1 makes register i read-only, sourced from reg_in.

Ports (DW = C_S_AXI_DATA_WIDTH, AW = C_S_AXI_ADDR_WIDTH):
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETn  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  AW/3/1/1  write address channel; PROT ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DW/DW/8/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  AW/3/1/1  read address channel; PROT ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DW/2/1/1  read data channel.
- reg_out  out  N_REGS*DW  flat RW register contents; register i at [i*DW +: DW]; RO slots drive 0.
- reg_in  in  N_REGS*DW  flat status inputs; used only for RO_MASK slots.
- reg_wr  out  N_REGS  one-cycle pulse per register on an accepted write, including partial-strobe writes.

## Operation
- Address decode: ADDR_LSB = log2(DW/8). Index = addr >> ADDR_LSB. Low ADDR_LSB bits are ignored. Index >= N_REGS is out of range.
- Each of AW, W and AR has a one-entry skid buffer. Its READY is registered and deasserts only when the buffer is occupied.
- Write fires when address and data are both available (skid or live) and B is not stalled (stall = BVALID && !BREADY).
  - AW and W may arrive in either order, any cycles apart.
  - The byte-lane update uses WSTRB.
  - Writes to RO registers, or out of range, leave storage unchanged; reg_wr stays low.
- Read fires when an address is available and R is not stalled.
  - RW registers return storage; RO registers return reg_in sampled at the fire edge.
  - Out-of-range reads return 0.
- Responses: RESP is OKAY, except out-of-range per Configuration.
- Simultaneous read and write to the same register in one cycle: the read returns the pre-write value.
- Reset (asynchronous assert, synchronous deassert is the integrator's job) clears:
  - all storage to 0;
  - BVALID, RVALID and reg_wr to 0;
  - RDATA to 0 and BRESP/RRESP to OKAY;
  - all skid buffers to empty.
  - AWREADY, WREADY and ARREADY reset to 1.
  - Reset mid-transaction discards the transaction; no response is issued.

## Timing
- Write: BVALID rises the cycle after the later of the AW/W handshakes, provided B is not stalled. reg_out updates and reg_wr pulses on that same edge.
- Read: RVALID rises the cycle after the AR handshake, provided R is not stalled. RDATA/RRESP are stable while RVALID && !RREADY.
- Throughput is one write and one read per clock while BREADY/RREADY are held high.
- Back-pressure on B or R:
  - One further address (and data) is accepted into the skid buffer.
  - The corresponding READY drops the next cycle.
  - READY re-rises the cycle after the stall clears.
- With both a skid entry and a stalled response present, no handshake completes on that channel.

## Configuration
- AXIL_REGFILE_SLVERR_EN defined: out-of-range accesses return BRESP/RRESP = SLVERR (2'b10). Writes to RO registers also return SLVERR.
- Undefined: every access returns OKAY; out-of-range and RO-write side effects remain none.

## Structure
- Package axil_regfile_pkg holds:
  - RESP_OKAY and RESP_SLVERR localparams;
  - a clog2 function;
  - the ADDR_LSB computation.
- Sub-module axil_skid_buffer (parametrised width, registered READY), instantiated for AW, W (data+strobe) and AR.
- Decode, storage, response registers and reg_wr generation live in the top.

## Test plan
- Reset: after ARESETn low, then high, read regs 0..15 -> all RDATA = 0, RRESP OKAY; AWREADY/WREADY/ARREADY = 1.
- Write 0xDEADBEEF to 0x08 with WSTRB = 4'b0101, over a prior value of 0 -> reg 2 reads 0x00AD00EF; reg_wr[2] pulses exactly one cycle, coincident with BVALID.
- W presented 3 cycles before AW (addr 0x0C, data 0x12345678) -> a single BVALID one cycle after the AW handshake; reg 3 = 0x12345678.
- RO_MASK bit 5 set, reg_in slot 5 = 0xCAFE0001; write 0xFFFFFFFF to 0x14 -> the read returns 0xCAFE0001, reg_wr[5] never asserts; BRESP is SLVERR with the macro, OKAY without.
- BREADY held low for 4 cycles across 3 back-to-back writes -> the second write is buffered, AWREADY/WREADY low by cycle 2, no write is lost, three BVALID beats follow in order, and all data lands.
- Read 0x100 with N_REGS = 16 -> RDATA = 0; RRESP SLVERR with the macro, OKAY without; a concurrent write to reg 0 is unaffected.
